// File: rtl/data_mem_if.sv
// data_mem_if: CPU-side request/response handshake of the data memory controller.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_ldst;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master(output req_valid, req_ldst, req_addr, req_wdata, input req_ready, resp_valid, resp_rdata, resp_err);
  modport slave(input req_valid, req_ldst, req_addr, req_wdata, output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store sequencer for a single-port BRAM plus switch/LED MMIO registers.
module data_mem_ctrl #(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00,
  parameter int          SW_W      = 8,
  parameter int          LED_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_if.slave         bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic [SW_W-1:0]   switches,
  output logic [LED_W-1:0]  led_out
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t state;
  logic [2:0] l_ldst;
  logic [1:0] l_off;
  logic [ADDR_W-1:0] l_waddr;
  logic [31:0] l_wdata;
  logic late;
  logic [SW_W-1:0] sw_meta, sw_sync;
  logic [31:0] a, mmio_word;
  logic [29:0] mmio_idx;
  logic is_st, is_half, is_word, misal, is_mmio, in_bram, mmio_sw, mmio_led, acc_err;
  function automatic logic [31:0] extract(input logic [2:0] l, input logic [1:0] o, input logic [31:0] w);
    logic [7:0] b;
    logic [15:0] h;
    b = 8'(w >> {o, 3'b000});
    h = o[1] ? w[31:16] : w[15:0];
    return l == 3'd0 ? {{24{b[7]}}, b} : l == 3'd1 ? {{16{h[15]}}, h} :
           l == 3'd3 ? {24'd0, b} : l == 3'd4 ? {16'd0, h} : w;
  endfunction
  function automatic logic [31:0] merge(input logic [2:0] l, input logic [1:0] o, input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] m, d;
    m = l == 3'd5 ? 32'hff << {o, 3'b000} : l == 3'd6 ? (o[1] ? 32'hffff_0000 : 32'h0000_ffff) : 32'hffff_ffff;
    d = l == 3'd5 ? {4{wd[7:0]}} : l == 3'd6 ? {2{wd[15:0]}} : wd;
    return (old & ~m) | (d & m);
  endfunction
  assign a         = bus.req_addr;
  assign is_st     = bus.req_ldst >= 3'd5;
  assign is_half   = bus.req_ldst == 3'd1 || bus.req_ldst == 3'd4 || bus.req_ldst == 3'd6;
  assign is_word   = bus.req_ldst == 3'd2 || bus.req_ldst == 3'd7;
  assign misal     = (is_half && a[0]) || (is_word && a[1:0] != 2'b00);
  assign is_mmio   = a >= MMIO_BASE;
  assign mmio_idx  = a[31:2] - MMIO_BASE[31:2];
  assign mmio_sw   = mmio_idx == 30'd0;
  assign mmio_led  = mmio_idx == 30'd1;
  assign in_bram   = (a >> (ADDR_W + 2)) == 32'd0;
  assign acc_err   = misal || (is_mmio ? !(mmio_sw || mmio_led) : !in_bram);
  assign mmio_word = mmio_led ? 32'(led_out) : 32'(sw_sync);
  assign bus.req_ready = state == IDLE;
  // Drive the request address straight through in IDLE so the BRAM read launches on the acceptance edge.
  assign mem_addr  = state == IDLE ? a[ADDR_W+1:2] : l_waddr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      l_ldst         <= '0;
      l_off          <= '0;
      l_waddr        <= '0;
      l_wdata        <= '0;
      late           <= 1'b0;
      sw_meta        <= '0;
      sw_sync        <= '0;
      mem_we         <= 1'b0;
      mem_wdata      <= '0;
      led_out        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      sw_meta        <= switches;
      sw_sync        <= sw_meta;
      case (state)
        IDLE: if (bus.req_valid) begin
          l_ldst  <= bus.req_ldst;
          l_off   <= a[1:0];
          l_waddr <= a[ADDR_W+1:2];
          l_wdata <= bus.req_wdata;
          // MMIO and error replies are ready now but held one cycle to match the BRAM load latency.
          if (acc_err || is_mmio) begin
            state          <= RESP;
            late           <= 1'b1;
            bus.resp_err   <= acc_err;
            bus.resp_rdata <= (acc_err || is_st) ? 32'd0 : extract(bus.req_ldst, a[1:0], mmio_word);
            if (!acc_err && is_st && mmio_led) led_out <= LED_W'(merge(bus.req_ldst, a[1:0], 32'(led_out), bus.req_wdata));
          end else begin
            state     <= bus.req_ldst == 3'd7 ? WR : RD;
            mem_we    <= bus.req_ldst == 3'd7;
            mem_wdata <= bus.req_wdata;
          end
        end
        RD: if (l_ldst >= 3'd5) begin
          state     <= WR;
          mem_we    <= 1'b1;
          mem_wdata <= merge(l_ldst, l_off, mem_rdata, l_wdata);
        end else begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= extract(l_ldst, l_off, mem_rdata);
        end
        WR: begin
          state          <= RESP;
          mem_we         <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        default: begin
          state          <= IDLE;
          bus.resp_valid <= late;
          late           <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed load/store/MMIO/error vectors with a queue scoreboard and BRAM model.
module tb_data_mem_ctrl;
  localparam int AW = 14;
  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic [7:0] switches;
  logic [31:0] led_out;
  logic [31:0] mem [2**AW];
  data_mem_if bus();
  data_mem_ctrl #(.ADDR_W(AW), .MMIO_BASE(32'hFFFF_FF00), .SW_W(8), .LED_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .switches(switches), .led_out(led_out));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  typedef struct {string name; logic [31:0] rdata; logic err; int lat; int acc;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, we_cnt = 0;
  logic we_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (mem_we && we_prev) chk("we_consecutive", 32'd1, 32'd0);
    we_prev = mem_we;
    if (!rst && bus.resp_valid) begin
      if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
        chk({e.name, "_err"}, 32'(bus.resp_err), 32'(e.err));
        chk({e.name, "_lat"}, cyc - e.acc, e.lat);
      end
    end
  end
  task automatic send(input logic [2:0] l, input logic [31:0] ad, input logic [31:0] wd);
    int t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
    if (!bus.req_ready) chk("ready_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b1; bus.req_ldst = l; bus.req_addr = ad; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic issue(input string name, input logic [2:0] l, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat);
    int t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
    if (!bus.req_ready) chk("ready_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b1; bus.req_ldst = l; bus.req_addr = ad; bus.req_wdata = wd;
    sb.push_back('{name, er, ee, lat, cyc + 1});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 20) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      chk({name, "_no_resp"}, 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    int w0, l0;
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_ldst = '0; bus.req_addr = '0; bus.req_wdata = '0;
    switches = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_led", led_out, 32'd0);
    rst = 1'b0;
    w0 = we_cnt;
    issue("sw100", 3'd7, 32'd100, 32'h123456f8, 32'd0, 1'b0, 1);
    chk("sw_we_pulses", we_cnt - w0, 32'd1);
    issue("lw100", 3'd2, 32'd100, 32'd0, 32'h123456f8, 1'b0, 1);
    issue("lh102", 3'd1, 32'd102, 32'd0, 32'h00001234, 1'b0, 1);
    issue("lb100", 3'd0, 32'd100, 32'd0, 32'hfffffff8, 1'b0, 1);
    issue("lbu100", 3'd3, 32'd100, 32'd0, 32'h000000f8, 1'b0, 1);
    issue("lhu100", 3'd4, 32'd100, 32'd0, 32'h000056f8, 1'b0, 1);
    w0 = we_cnt;
    issue("sb101", 3'd5, 32'd101, 32'hffffffab, 32'd0, 1'b0, 2);
    chk("sb_we_pulses", we_cnt - w0, 32'd1);
    issue("lw_after_sb", 3'd2, 32'd100, 32'd0, 32'h1234abf8, 1'b0, 1);
    issue("sh102", 3'd6, 32'd102, 32'hffffde98, 32'd0, 1'b0, 2);
    issue("lw_after_sh", 3'd2, 32'd100, 32'd0, 32'hde98abf8, 1'b0, 1);
    w0 = we_cnt;
    issue("sw_led", 3'd7, 32'hFFFF_FF04, 32'd5, 32'd0, 1'b0, 1);
    chk("led_after_sw", led_out, 32'd5);
    switches = 8'h5a;
    repeat (3) @(negedge clk);
    issue("lw_sw", 3'd2, 32'hFFFF_FF00, 32'd0, 32'h0000005a, 1'b0, 1);
    issue("lw_led", 3'd2, 32'hFFFF_FF04, 32'd0, 32'h00000005, 1'b0, 1);
    issue("sb_led", 3'd5, 32'hFFFF_FF05, 32'h000000ff, 32'd0, 1'b0, 1);
    chk("led_after_sb", led_out, 32'h0000ff05);
    chk("mmio_no_we", we_cnt - w0, 32'd0);
    w0 = we_cnt; l0 = led_out;
    issue("err_lw102", 3'd2, 32'd102, 32'd0, 32'd0, 1'b1, 1);
    issue("err_sh101", 3'd6, 32'd101, 32'hffff, 32'd0, 1'b1, 1);
    issue("err_range", 3'd2, 32'(4 * 2**AW), 32'd0, 32'd0, 1'b1, 1);
    issue("err_mmio", 3'd2, 32'hFFFF_FF10, 32'd0, 32'd0, 1'b1, 1);
    issue("err_sw_mmio", 3'd7, 32'hFFFF_FF10, 32'hdead, 32'd0, 1'b1, 1);
    chk("err_no_we", we_cnt - w0, 32'd0);
    chk("err_led", led_out, l0);
    w0 = we_cnt;
    send(3'd5, 32'd100, 32'h00000077);
    rst = 1'b1;
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_led", led_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort_no_we", we_cnt - w0, 32'd0);
    issue("lw_after_abort", 3'd2, 32'd100, 32'd0, 32'hde98abf8, 1'b0, 1);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
